// File: rtl/frame_serializer.sv
// frame_serializer: wraps up to NUM_CHANNELS words as HEADER, data, LEN, FOOTER.
// Define FRAME_CHECKSUM_EN to insert an XOR checksum word between LEN and FOOTER.
module frame_serializer #(
    parameter int                DATA_W       = 8,
    parameter int                NUM_CHANNELS = 16,
    parameter logic [DATA_W-1:0] HEADER       = DATA_W'(8'hAA),
    parameter logic [DATA_W-1:0] FOOTER       = DATA_W'(8'hFF),
    parameter int                TIMEOUT      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sof,
    output logic              dout_eof,
    output logic              dout_short
);

    localparam int CW = $clog2(NUM_CHANNELS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, LEN, CSUM, FTR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, LEN, FTR} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   ch_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            short_flag;
    logic            load;
    logic            accept;
`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign load      = !dout_valid || dout_ready;
    assign din_ready = (state == DATA) && load;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_cnt     <= '0;
            idle_cnt   <= '0;
            short_flag <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            dout_short <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            // idle_cnt also runs while the output is backpressured
            if (state == DATA) begin
                if (accept)
                    idle_cnt <= '0;
                else if (idle_cnt != IW'(TIMEOUT))
                    idle_cnt <= idle_cnt + 1'b1;
            end
            if (load) begin
                dout_sof   <= 1'b0;
                dout_eof   <= 1'b0;
                dout_short <= 1'b0;
                unique case (state)
                    IDLE: begin
                        // a still-valid FOOTER forces one bubble before the next HEADER
                        if (din_valid && !dout_valid) begin
                            dout       <= HEADER;
                            dout_valid <= 1'b1;
                            dout_sof   <= 1'b1;
                            idle_cnt   <= '0;
                            state      <= DATA;
                        end else begin
                            dout_valid <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            dout       <= din;
                            dout_valid <= 1'b1;
                            ch_cnt     <= ch_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                            csum       <= csum ^ din;
`endif
                            if (ch_cnt == CW'(NUM_CHANNELS - 1))
                                state <= LEN;
                        end else begin
                            dout_valid <= 1'b0;
                            if (idle_cnt >= IW'(TIMEOUT - 1)) begin
                                short_flag <= 1'b1;
                                state      <= LEN;
                            end
                        end
                    end
                    LEN: begin
                        dout       <= DATA_W'(ch_cnt);
                        dout_valid <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        state      <= CSUM;
`else
                        state      <= FTR;
`endif
                    end
`ifdef FRAME_CHECKSUM_EN
                    CSUM: begin
                        dout       <= csum;
                        dout_valid <= 1'b1;
                        state      <= FTR;
                    end
`endif
                    FTR: begin
                        dout       <= FOOTER;
                        dout_valid <= 1'b1;
                        dout_eof   <= 1'b1;
                        dout_short <= short_flag;
                        ch_cnt     <= '0;
                        idle_cnt   <= '0;
                        short_flag <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        csum       <= '0;
`endif
                        state      <= IDLE;
                    end
                    default: begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer (NUM_CHANNELS=4, TIMEOUT=5).
// Define FRAME_CHECKSUM_EN for both files to cover the checksum build.
module tb_frame_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       dout_sof, dout_eof, dout_short;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    bit          chk_gap = 1'b0;
    bit          gap_armed = 1'b0;
    int          gap = 0;
    bit          prev_stall = 1'b0;
    logic [10:0] hold_w = '0;

    frame_serializer #(
        .DATA_W(8), .NUM_CHANNELS(4), .HEADER(8'hAA),
        .FOOTER(8'hFF), .TIMEOUT(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_sof(dout_sof),
        .dout_eof(dout_eof), .dout_short(dout_short)
    );

    always #5 clk = ~clk;

    task automatic ex(input logic [7:0] w, input bit s, input bit e, input bit sh);
        exp_q.push_back({s, e, sh, w});
    endtask

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pops and compares on every output transfer
    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        cur = {dout_sof, dout_eof, dout_short, dout};
        if (!rst_n) begin
            prev_stall = 1'b0;
            gap = 0;
            gap_armed = 1'b0;
        end else begin
            if (!dout_valid) gap++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout_word", cur, e);
                end
                if (dout_sof && gap_armed) begin
                    chk("btb_gap", 11'(gap), 11'd1);
                    gap_armed = 1'b0;
                end
                if (dout_eof) begin
                    gap = 0;
                    gap_armed = chk_gap;
                end
            end
            if (dout_valid && !dout_ready) begin
                chk("stall_din_ready", {10'd0, din_ready}, 11'd0);
                if (prev_stall) chk("stall_hold", cur, hold_w);
            end
            prev_stall = dout_valid && !dout_ready;
            hold_w = cur;
        end
    end

    task automatic feed(input logic [7:0] w);
        int t;
        t = 0;
        din = w;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL feed_timeout: got no accept want accept of %h", w);
                break;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain_empty", 11'(exp_q.size()), 11'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {dout_sof, dout_eof, dout_short, dout}, 11'd0);
        chk({name, "_valid"}, {9'd0, dout_valid, din_ready}, 11'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // full frame
        ex(8'hAA, 1, 0, 0);
        ex(8'h01, 0, 0, 0); ex(8'h02, 0, 0, 0);
        ex(8'h03, 0, 0, 0); ex(8'h04, 0, 0, 0);
        ex(8'h04, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        ex(8'h04, 0, 0, 0);
`endif
        ex(8'hFF, 0, 1, 0);
        for (int i = 1; i <= 4; i++) feed(8'(i));
        din_valid = 1'b0;
        drain();

        // timeout after two words
        ex(8'hAA, 1, 0, 0);
        ex(8'h11, 0, 0, 0); ex(8'h22, 0, 0, 0);
        ex(8'h02, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        ex(8'h33, 0, 0, 0);
`endif
        ex(8'hFF, 0, 1, 1);
        feed(8'h11);
        feed(8'h22);
        din_valid = 1'b0;
        drain();

        // backpressure mid-DATA
        ex(8'hAA, 1, 0, 0);
        ex(8'h5A, 0, 0, 0); ex(8'hC3, 0, 0, 0);
        ex(8'h0F, 0, 0, 0); ex(8'h80, 0, 0, 0);
        ex(8'h04, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        ex(8'h16, 0, 0, 0);
`endif
        ex(8'hFF, 0, 1, 0);
        fork
            begin
                feed(8'h5A); feed(8'hC3); feed(8'h0F); feed(8'h80);
                din_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 dout_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 dout_ready = 1'b1;
            end
        join
        drain();

        // zero-length frame
        ex(8'hAA, 1, 0, 0);
        ex(8'h00, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        ex(8'h00, 0, 0, 0);
`endif
        ex(8'hFF, 0, 1, 1);
        din = 8'h77;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        drain();

        // reset mid-DATA, then a fresh two-word frame
        ex(8'hAA, 1, 0, 0);
        ex(8'h31, 0, 0, 0); ex(8'h32, 0, 0, 0);
        feed(8'h31);
        feed(8'h32);
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk_zero("async_reset");
        chk("reset_q_empty", 11'(exp_q.size()), 11'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ex(8'hAA, 1, 0, 0);
        ex(8'h41, 0, 0, 0); ex(8'h42, 0, 0, 0);
        ex(8'h02, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        ex(8'h03, 0, 0, 0);
`endif
        ex(8'hFF, 0, 1, 1);
        feed(8'h41);
        feed(8'h42);
        din_valid = 1'b0;
        drain();

        // back-to-back frames, din_valid held high
        chk_gap = 1'b1;
        for (int f = 0; f < 2; f++) begin
            ex(8'hAA, 1, 0, 0);
            for (int i = 0; i < 4; i++) ex(8'(f * 4 + i + 5), 0, 0, 0);
            ex(8'h04, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
            ex(f == 0 ? 8'h0C : 8'h04, 0, 0, 0);
`endif
            ex(8'hFF, 0, 1, 0);
        end
        for (int i = 5; i <= 12; i++) feed(8'(i));
        din_valid = 1'b0;
        drain();
        chk_gap = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
